// File: rtl/seq_pattern_detector_if.sv
// ----------------------------------------------------------------------------
// seq_pattern_detector_if
//   Groups the configuration, serial-stream and status signals of the
//   pattern detector into one bundle.
//
//   master : drives cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid,
//            in and cnt_clr. Observes match, match_cnt and cfg_err.
//   slave  : the detector side, with the opposite directions.
//
//   Parameters must match those of the detector that is attached.
// ----------------------------------------------------------------------------
interface seq_pattern_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in, cnt_clr,
        input  match, match_cnt, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in, cnt_clr,
        output match, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// ----------------------------------------------------------------------------
// seq_pattern_detector
//   Serial pattern detector with a runtime-programmable pattern of
//   1..MAX_LEN bits, overlapping or non-overlapping detection and a
//   saturating match counter.
//
//   Ports:
//     clk   : system clock, all state on the rising edge
//     rstn  : asynchronous active-low reset
//     bus   : seq_pattern_detector_if.slave
//             cfg_load/cfg_pattern/cfg_len/cfg_overlap - configuration
//             in_valid/in                              - qualified serial bit
//             cnt_clr                                  - clear match_cnt
//             match     - one-cycle registered detection pulse
//             match_cnt - saturating detection count
//             cfg_err   - loaded length is illegal
//
//   Pattern bit [len-1] is the first bit received, bit [0] the last.
// ----------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    seq_pattern_detector_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {
        ST_UNCFG,   // no valid configuration, input ignored
        ST_FILL,    // fewer than len bits held since config / last match
        ST_SCAN     // at least len bits held, comparing every bit
    } state_t;

    state_t             r_state,   w_state_next;
    logic [MAX_LEN-1:0] r_hist,    w_hist_next;
    logic [LEN_W-1:0]   r_fill,    w_fill_next;
    logic [MAX_LEN-1:0] r_pattern, w_pattern_next;
    logic [LEN_W-1:0]   r_len,     w_len_next;
    logic               r_overlap, w_overlap_next;
    logic               r_match,   w_match_next;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_next;
    logic               r_cfg_err, w_cfg_err_next;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_shift;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_detect;
    logic               w_len_bad;

    // Bit i of the mask selects history bit i for comparison (i < len).
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_accept   = bus.in_valid && !bus.cfg_load && (r_state != ST_UNCFG);
    assign w_shift    = {r_hist[MAX_LEN-2:0], bus.in};
    assign w_fill_inc = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
    assign w_detect   = w_accept && (w_fill_inc == r_len) &&
                        (((w_shift ^ r_pattern) & w_mask) == '0);
    assign w_len_bad  = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_hist_next    = r_hist;
        w_fill_next    = r_fill;
        w_pattern_next = r_pattern;
        w_len_next     = r_len;
        w_overlap_next = r_overlap;
        w_match_next   = 1'b0;
        w_cnt_next     = r_cnt;
        w_cfg_err_next = r_cfg_err;

        if (bus.cfg_load) begin
            // A new configuration wins over any same-cycle input bit.
            w_pattern_next = bus.cfg_pattern;
            w_len_next     = bus.cfg_len;
            w_overlap_next = bus.cfg_overlap;
            w_hist_next    = '0;
            w_fill_next    = '0;
            w_cnt_next     = '0;
            w_cfg_err_next = w_len_bad;
            w_state_next   = w_len_bad ? ST_UNCFG : ST_FILL;
        end else begin
            if (w_accept) begin
                w_hist_next  = w_shift;
                w_fill_next  = w_fill_inc;
                w_state_next = (w_fill_inc == r_len) ? ST_SCAN : ST_FILL;
                if (w_detect) begin
                    w_match_next = 1'b1;
                    // Non-overlapping: history stays, but is not compared
                    // again until len fresh bits have arrived.
                    if (!r_overlap) begin
                        w_fill_next  = '0;
                        w_state_next = ST_FILL;
                    end
                end
            end

            // Clear has priority over a same-cycle detection.
            if (bus.cnt_clr) begin
                w_cnt_next = '0;
            end else if (w_detect && (r_cnt != {CNT_W{1'b1}})) begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_UNCFG;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_match   <= 1'b0;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_hist    <= w_hist_next;
            r_fill    <= w_fill_next;
            r_pattern <= w_pattern_next;
            r_len     <= w_len_next;
            r_overlap <= w_overlap_next;
            r_match   <= w_match_next;
            r_cnt     <= w_cnt_next;
            r_cfg_err <= w_cfg_err_next;
        end
    end

    assign bus.match     = r_match;
    assign bus.match_cnt = r_cnt;
    assign bus.cfg_err   = r_cfg_err;

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial pattern detector.
- Detects a runtime-programmable bit pattern of 1..MAX_LEN bits on a qualified serial input.
- Supports overlapping and non-overlapping detection and keeps a saturating match counter.
- Successor to the fixed "0110" Moore detectors in the sequence-detection labs; sits directly on a serial bit stream between the input synchroniser and the status/LED logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(MAX_LEN)+1, width of the length field (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- cfg_load  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  input  MAX_LEN  pattern bits; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  input  1  in is sampled only when high.
- in  input  1  serial data bit.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  one-cycle registered pulse per detection.
- match_cnt  output  CNT_W  saturating count of detections.
- cfg_err  output  1  high while the loaded length is illegal.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=UNCFG; hist, fill, pattern and len registers = 0.
  - match=0, match_cnt=0, cfg_err=0.
- FSM states:
  - UNCFG: no valid configuration.
  - FILL: fewer than len valid bits held since the last config or non-overlap match.
  - SCAN: at least len bits held; compare active.
- cfg_load=1:
  - Latches pattern, len and overlap.
  - Clears hist, fill, match and match_cnt.
  - If cfg_len==0 or cfg_len>MAX_LEN: state->UNCFG, cfg_err=1. Otherwise state->FILL, cfg_err=0.
  - cfg_load has priority over in_valid in the same cycle; that input bit is dropped.
- UNCFG: input is ignored; match is never asserted.
- Accepted bit (in_valid=1, no cfg_load, state!=UNCFG):
  - hist_next = {hist[MAX_LEN-2:0], in}.
  - fill_next = min(fill+1, len).
- Detection: accepted bit with fill_next==len and hist_next[len-1:0]==pattern[len-1:0].
- Latency: match is registered high in the cycle after the clock edge that accepted the last pattern bit. It is high for exactly one cycle unless the next accepted bit also detects. match=0 in any cycle following no detection, including in_valid=0 cycles.
- State transitions:
  - FILL->SCAN when fill_next==len.
  - On detection with overlap=1: stay in SCAN, fill is kept.
  - On detection with overlap=0: fill<-0, state->FILL. hist is retained but is not compared until len new bits arrive.
  - len==1 with overlap=0: every matching bit detects; fill returns to 0 and refills on the next bit.
- in_valid=0: hist, fill and state hold.
- match_cnt:
  - Increments by 1 on each detection.
  - Saturates at 2^CNT_W-1.
  - cnt_clr forces 0 and has priority over a same-cycle detection (result 0, match still pulses).
- Reset asserted mid-stream: everything returns to reset values immediately. After release the block is UNCFG until cfg_load.

Test Plan:
- Reset, then cfg_load len=4 pattern=4'b0110 overlap=1. Feed 0,1,1,0,1,1,0 on consecutive valid cycles -> match pulses after bit 4 and after bit 7; match_cnt=2.
- Same stream with overlap=0 -> single match after bit 4; match_cnt=1; no match at bit 7.
- len=4 pattern 0110 with in_valid low for 3 cycles between each bit, and in toggling during the gaps -> exactly one match, one cycle after the 4th valid bit; gap values are ignored.
- len=8 pattern=8'hA5: feed 1,0,1,0,0,1,0,1 -> match after bit 8. Feed 7 bits only -> no match while fill<8.
- cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err=1 and no match on any stream. A valid cfg_load afterwards clears cfg_err.
- With CNT_W=2, generate 5 overlapping len=1 matches -> match_cnt=3 (saturated). Then cnt_clr coincident with a detection -> match=1, match_cnt=0.
- Assert rstn low mid-pattern (after 0,1,1) -> outputs 0 immediately. After release, feeding 0 produces no match (UNCFG).
